// File: rtl/lcd_frame_refresh.sv
// Frame-buffer refresher feeding the hd44780 I2C character-LCD driver.
// Optional LCD_DIRTY_SKIP_EN: rows untouched since their last paint are skipped.
module lcd_frame_refresh #(
    parameter int COLS           = 20,
    parameter int ROWS           = 4,
    parameter int POWERUP_CYCLES = 100_000_000,
    parameter int HS_TIMEOUT     = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_row,
    input  logic [4:0] wr_col,
    input  logic [7:0] wr_data,
    output logic [1:0] lcd_cmd,
    output logic [8:0] lcd_vchr,
    input  logic       lcd_busy,
    output logic       ready,
    output logic       frame_done,
    output logic       timeout_err
);

    localparam logic [1:0]  CMD_IDLE  = 2'd0;
    localparam logic [1:0]  CMD_INIT  = 2'd1;
    localparam logic [1:0]  CMD_WRITE = 2'd2;

    localparam logic [31:0] PWR_LAST  = 32'(POWERUP_CYCLES - 1);
    localparam logic [31:0] TO_LAST   = 32'(HS_TIMEOUT - 1);
    localparam logic [1:0]  ROW_LAST  = 2'(ROWS - 1);
    localparam logic [4:0]  COL_LAST  = 5'(COLS - 1);
    localparam logic [2:0]  ROW_LIMIT = 3'(ROWS);
    localparam logic [5:0]  COL_LIMIT = 6'(COLS);

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_REQ,
        INIT_WAIT,
        ROW_ADDR,
        CHAR,
        REQ,
        DONE_WAIT
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [7:0]  cells [ROWS][COLS];
    logic [31:0] cnt;
    logic [1:0]  row;
    logic [4:0]  col;
    logic        last_addr;
    logic        wr_ok;
    logic        cnt_hit;
    logic        hs_timeout;
    logic        row_clean;
    logic        row_end;
    logic        frame_wrap;

    function automatic logic [7:0] row_base(input logic [1:0] r);
        case (r)
            2'd0:    return 8'h00;
            2'd1:    return 8'h40;
            2'd2:    return 8'h14;
            default: return 8'h54;
        endcase
    endfunction

    assign wr_ok   = wr_en && ({1'b0, wr_row} < ROW_LIMIT) && ({1'b0, wr_col} < COL_LIMIT);
    assign cnt_hit = (cnt == TO_LAST);

`ifdef LCD_DIRTY_SKIP_EN
    logic [ROWS-1:0] dirty;
    assign row_clean = !dirty[row];
`else
    assign row_clean = 1'b0;
`endif

    // A timeout only fires while the handshake is actually stalled.
    always_comb begin
        hs_timeout = 1'b0;
        case (state)
            INIT_REQ:  hs_timeout = cnt_hit && !lcd_busy;
            INIT_WAIT: hs_timeout = cnt_hit && lcd_busy;
            REQ:       hs_timeout = cnt_hit && !lcd_busy;
            DONE_WAIT: hs_timeout = cnt_hit && lcd_busy;
            default:   hs_timeout = 1'b0;
        endcase
    end

    assign row_end    = (state == DONE_WAIT) && !lcd_busy && !last_addr && (col == COL_LAST);
    assign frame_wrap = (row_end || ((state == ROW_ADDR) && row_clean)) && (row == ROW_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PWR_WAIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            PWR_WAIT: begin
                if (cnt == PWR_LAST) state_next = INIT_REQ;
            end
            INIT_REQ: begin
                if (lcd_busy) state_next = INIT_WAIT;
            end
            INIT_WAIT: begin
                if (!lcd_busy)      state_next = ROW_ADDR;
                else if (hs_timeout) state_next = INIT_REQ;
            end
            ROW_ADDR: begin
                state_next = row_clean ? ROW_ADDR : REQ;
            end
            CHAR: begin
                state_next = REQ;
            end
            REQ: begin
                if (lcd_busy)        state_next = DONE_WAIT;
                else if (hs_timeout) state_next = ROW_ADDR;
            end
            DONE_WAIT: begin
                if (!lcd_busy)       state_next = (last_addr || (col != COL_LAST)) ? CHAR : ROW_ADDR;
                else if (hs_timeout) state_next = ROW_ADDR;
            end
            default: state_next = PWR_WAIT;
        endcase
    end

    always_comb begin
        lcd_cmd = CMD_IDLE;
        case (state)
            INIT_REQ: lcd_cmd = CMD_INIT;
            REQ:      lcd_cmd = CMD_WRITE;
            default:  lcd_cmd = CMD_IDLE;
        endcase
    end

    // One counter serves both the power-up delay and the handshake watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if ((state_next != state) || hs_timeout) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    cells[r][c] <= 8'h20;
                end
            end
        end else if (wr_ok) begin
            cells[wr_row][wr_col] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcd_vchr    <= '0;
            row         <= '0;
            col         <= '0;
            last_addr   <= 1'b0;
            ready       <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            frame_done <= frame_wrap;
            if (hs_timeout) timeout_err <= 1'b1;
            case (state)
                INIT_WAIT: begin
                    if (!lcd_busy) ready <= 1'b1;
                end
                ROW_ADDR: begin
                    if (row_clean) begin
                        row <= (row == ROW_LAST) ? 2'd0 : row + 2'd1;
                    end else begin
                        lcd_vchr  <= {1'b1, 8'h80 | row_base(row)};
                        last_addr <= 1'b1;
                        col       <= '0;
                    end
                end
                CHAR: begin
                    lcd_vchr  <= {1'b0, cells[row][col]};
                    last_addr <= 1'b0;
                end
                REQ: begin
                    if (hs_timeout) col <= '0;
                end
                DONE_WAIT: begin
                    if (!lcd_busy) begin
                        if (last_addr) begin
                            col <= '0;
                        end else if (col != COL_LAST) begin
                            col <= col + 5'd1;
                        end else begin
                            col <= '0;
                            row <= (row == ROW_LAST) ? 2'd0 : row + 2'd1;
                        end
                    end else if (hs_timeout) begin
                        col <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LCD_DIRTY_SKIP_EN
    // Host writes take priority so a write landing mid-paint forces a repaint next pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty <= '1;
        end else begin
            if ((state == ROW_ADDR) && !row_clean) dirty[row] <= 1'b0;
            if (((state == REQ) || (state == DONE_WAIT)) && hs_timeout) dirty[row] <= 1'b1;
            if (wr_ok) dirty[wr_row] <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lcd_frame_refresh.sv
// Self-checking bench for lcd_frame_refresh with a behavioural LCD driver and frame model.
module tb_lcd_frame_refresh;

    localparam int COLS = 20;
    localparam int ROWS = 4;
    localparam int PWR  = 10;
    localparam int HST  = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_row = '0;
    logic [4:0] wr_col = '0;
    logic [7:0] wr_data = '0;
    logic [1:0] lcd_cmd;
    logic [8:0] lcd_vchr;
    logic       lcd_busy = 1'b0;
    logic       ready;
    logic       frame_done;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] model [ROWS][COLS];
    logic [8:0] wlog [$];
    int         fd_marks [$];
    int         fd_times [$];
    int         fd_seen = 0;
    int         cyc = 0;
    int         init_count = 0;
    int         viol = 0;
    int         busy_left = 0;
    bit         ignore = 1'b0;

    lcd_frame_refresh #(
        .COLS(COLS),
        .ROWS(ROWS),
        .POWERUP_CYCLES(PWR),
        .HS_TIMEOUT(HST)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .wr_row(wr_row),
        .wr_col(wr_col),
        .wr_data(wr_data),
        .lcd_cmd(lcd_cmd),
        .lcd_vchr(lcd_vchr),
        .lcd_busy(lcd_busy),
        .ready(ready),
        .frame_done(frame_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Driver model: accepts a request, stays busy for 3 cycles, logs every transaction.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            lcd_busy  = 1'b0;
            busy_left = 0;
        end else begin
            if (frame_done) begin
                fd_marks.push_back(wlog.size());
                fd_times.push_back(cyc);
            end
            if (lcd_busy) begin
                if (lcd_cmd != 2'd0) viol++;
                busy_left--;
                if (busy_left == 0) lcd_busy = 1'b0;
            end else if (lcd_cmd != 2'd0 && !ignore) begin
                lcd_busy  = 1'b1;
                busy_left = 3;
                if (lcd_cmd == 2'd2)      wlog.push_back(lcd_vchr);
                else if (lcd_cmd == 2'd1) init_count++;
                else                      viol++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got hang expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [8:0] addr_of(input int r);
        case (r)
            0:       return 9'h180;
            1:       return 9'h1C0;
            2:       return 9'h194;
            3:       return 9'h1D4;
            default: return 9'h000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                model[r][c] = 8'h20;
    endtask

    task automatic host_write(input int r, input int c, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_row  = 2'(r);
        wr_col  = 5'(c);
        wr_data = d;
        if (c < COLS) model[r][c] = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_frame(output int lo, output int hi, output int dt, output bit ok);
        int n;
        ok = 1'b0;
        lo = 0;
        hi = 0;
        dt = 0;
        n  = 0;
        while (n < 3000 && fd_marks.size() <= fd_seen) begin
            tick();
            n++;
        end
        checks++;
        if (fd_marks.size() > fd_seen) begin
            ok = 1'b1;
            lo = (fd_seen == 0) ? 0 : fd_marks[fd_seen-1];
            hi = fd_marks[fd_seen];
            dt = (fd_seen == 0) ? 0 : fd_times[fd_seen] - fd_times[fd_seen-1];
            fd_seen++;
        end else begin
            errors++;
            $display("[TB] FAIL frame_wait: got no frame_done in %0d cycles, expected a pulse", n);
        end
    endtask

    task automatic compare_frame(input string name, input logic [3:0] mask, input int lo, input int hi);
        logic [8:0] expq [$];
        for (int r = 0; r < ROWS; r++) begin
            if (mask[r]) begin
                expq.push_back(addr_of(r));
                for (int c = 0; c < COLS; c++) expq.push_back({1'b0, model[r][c]});
            end
        end
        checks++;
        if (hi - lo != expq.size()) begin
            errors++;
            $display("[TB] FAIL %s_count: got %0d writes, expected %0d", name, hi - lo, expq.size());
        end
        for (int i = 0; i < expq.size() && lo + i < hi; i++) begin
            checks++;
            if (wlog[lo+i] !== expq[i]) begin
                errors++;
                $display("[TB] FAIL %s_entry%0d: got %h, expected %h", name, i, wlog[lo+i], expq[i]);
            end
        end
    endtask

    task automatic check_frame(input string name, input logic [3:0] mask);
        int lo, hi, dt;
        bit ok;
        wait_frame(lo, hi, dt, ok);
        if (ok) compare_frame(name, mask, lo, hi);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        tick();
        tick();
        checks++; if (lcd_cmd !== 2'd0)     begin errors++; $display("[TB] FAIL reset_cmd: got %0d expected 0", lcd_cmd); end
        checks++; if (lcd_vchr !== 9'd0)    begin errors++; $display("[TB] FAIL reset_vchr: got %h expected 000", lcd_vchr); end
        checks++; if (ready !== 1'b0)       begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
        checks++; if (frame_done !== 1'b0)  begin errors++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frame_done); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %b expected 0", timeout_err); end
    endtask

    // Releases reset, optionally writes during power-up, and times the INIT request.
    task automatic test_powerup(input bit with_writes);
        int  k;
        int  r;
        bit  found;
        wlog.delete();
        fd_marks.delete();
        fd_times.delete();
        fd_seen    = 0;
        init_count = 0;
        tick();
        rst_n = 1'b1;
        found = 1'b0;
        k     = 0;
        for (int i = 1; i <= 40 && !found; i++) begin
            tick();
            if (lcd_cmd == 2'd1) begin
                found = 1'b1;
                k     = i;
            end else if (with_writes && i == 1) begin
                wr_en = 1'b1; wr_row = 2'd2; wr_col = 5'd5; wr_data = 8'h41;
                model[2][5] = 8'h41;
            end else if (with_writes && i <= 7) begin
                r = $urandom_range(0, 2);
                if (r == 2) r = 3;
                wr_en   = 1'b1;
                wr_row  = 2'(r);
                wr_col  = 5'($urandom_range(0, COLS - 1));
                wr_data = 8'($urandom);
                model[r][wr_col] = wr_data;
            end else if (with_writes && i == 8) begin
                wr_en   = 1'b1;
                wr_row  = 2'd1;
                wr_col  = 5'($urandom_range(COLS, 31));
                wr_data = 8'($urandom);
            end else begin
                wr_en = 1'b0;
            end
        end
        wr_en = 1'b0;
        checks++; if (k != PWR)     begin errors++; $display("[TB] FAIL powerup_delay: got INIT at cycle %0d, expected %0d", k, PWR); end
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL ready_early: got %b expected 0", ready); end
        for (int i = 0; i < 40 && ready !== 1'b1; i++) tick();
        checks++; if (ready !== 1'b1)    begin errors++; $display("[TB] FAIL ready_rise: got %b expected 1", ready); end
        checks++; if (lcd_busy !== 1'b0) begin errors++; $display("[TB] FAIL ready_busy: got busy %b expected 0", lcd_busy); end
    endtask

    task automatic test_first_frame();
        check_frame("frame1", 4'hF);
        checks++; if (wlog.size() == 0 || wlog[0] !== 9'h180) begin errors++; $display("[TB] FAIL first_write: got %h expected 180", (wlog.size() == 0) ? 9'h000 : wlog[0]); end
        checks++; if (init_count != 1) begin errors++; $display("[TB] FAIL init_count: got %0d expected 1", init_count); end
    endtask

`ifndef LCD_DIRTY_SKIP_EN
    task automatic test_random_frames();
        int lo, hi, dt;
        bit ok;
        for (int round = 0; round < 2; round++) begin
            wait_frame(lo, hi, dt, ok);
            for (int i = 0; i < 40; i++) begin
                wr_en   = ($urandom_range(0, 3) != 0);
                wr_row  = 2'($urandom_range(0, 3));
                wr_col  = 5'($urandom_range(0, 24));
                wr_data = 8'($urandom);
                if (wr_en && wr_col < COLS) model[wr_row][wr_col] = wr_data;
                tick();
            end
            wr_en = 1'b0;
            wait_frame(lo, hi, dt, ok);
            check_frame("rand", 4'hF);
        end
    endtask
`else
    task automatic test_skip();
        int  lo, hi, dt;
        bit  ok;
        bit  painted;
        for (int p = 0; p < 2; p++) begin
            wait_frame(lo, hi, dt, ok);
            checks++; if (hi != lo) begin errors++; $display("[TB] FAIL skip_idle_writes: got %0d expected 0", hi - lo); end
            checks++; if (dt != ROWS) begin errors++; $display("[TB] FAIL skip_idle_period: got %0d expected %0d", dt, ROWS); end
        end
        host_write(3, 7, 8'($urandom));
        painted = 1'b0;
        for (int p = 0; p < 4 && !painted; p++) begin
            wait_frame(lo, hi, dt, ok);
            if (ok && hi > lo) begin
                painted = 1'b1;
                compare_frame("skip_row3", 4'b1000, lo, hi);
            end
        end
        checks++; if (!painted) begin errors++; $display("[TB] FAIL skip_repaint: got no painted pass, expected row 3 repaint"); end
        wait_frame(lo, hi, dt, ok);
        checks++; if (hi != lo) begin errors++; $display("[TB] FAIL skip_after_writes: got %0d expected 0", hi - lo); end
    endtask
`endif

    task automatic test_timeout();
        int         n;
        int         r;
        int         size0;
        bit         hit;
        logic [8:0] stalled;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_pre: got %b expected 0", timeout_err); end
        host_write(1, 3, 8'($urandom));
        for (int i = 0; i < 1000 && lcd_busy !== 1'b1; i++) tick();
        ignore  = 1'b1;
        n       = 0;
        hit     = 1'b0;
        stalled = '0;
        for (int i = 0; i < 400 && !hit; i++) begin
            tick();
            if (timeout_err === 1'b1) hit = 1'b1;
            else if (lcd_cmd == 2'd2) begin
                n++;
                stalled = lcd_vchr;
            end
        end
        checks++; if (!hit)            begin errors++; $display("[TB] FAIL timeout_set: got %b expected 1", timeout_err); end
        checks++; if (n != HST)        begin errors++; $display("[TB] FAIL timeout_cycles: got %0d expected %0d", n, HST); end
        checks++; if (lcd_cmd !== 2'd0) begin errors++; $display("[TB] FAIL timeout_cmd: got %0d expected 0", lcd_cmd); end
        r = -1;
        if (stalled[8]) begin
            for (int j = 0; j < ROWS; j++) if (addr_of(j) == stalled) r = j;
        end else begin
            for (int j = wlog.size() - 1; j >= 0 && r < 0; j--) begin
                if (wlog[j][8]) for (int q = 0; q < ROWS; q++) if (addr_of(q) == wlog[j]) r = q;
            end
        end
        size0  = wlog.size();
        ignore = 1'b0;
        for (int i = 0; i < 60 && wlog.size() <= size0; i++) tick();
        checks++;
        if (wlog.size() <= size0 || wlog[size0] !== addr_of(r)) begin
            errors++;
            $display("[TB] FAIL timeout_reissue: got %h expected %h", (wlog.size() > size0) ? wlog[size0] : 9'h000, addr_of(r));
        end
    endtask

    task automatic test_reset_mid();
        host_write(0, 0, 8'($urandom));
        for (int i = 0; i < 1000 && lcd_cmd !== 2'd2; i++) tick();
        checks++; if (lcd_cmd !== 2'd2) begin errors++; $display("[TB] FAIL mid_req_seen: got %0d expected 2", lcd_cmd); end
        rst_n = 1'b0;
        #1;
        checks++; if (lcd_cmd !== 2'd0)     begin errors++; $display("[TB] FAIL mid_reset_cmd: got %0d expected 0", lcd_cmd); end
        checks++; if (lcd_vchr !== 9'd0)    begin errors++; $display("[TB] FAIL mid_reset_vchr: got %h expected 000", lcd_vchr); end
        checks++; if (ready !== 1'b0)       begin errors++; $display("[TB] FAIL mid_reset_ready: got %b expected 0", ready); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_timeout: got %b expected 0", timeout_err); end
        clear_model();
        tick();
        test_powerup(1'b0);
        check_frame("blank", 4'hF);
    endtask

    initial begin
        $display("[TB] starting lcd_frame_refresh bench");
        clear_model();
        test_reset();
        test_powerup(1'b1);
        test_first_frame();
`ifdef LCD_DIRTY_SKIP_EN
        test_skip();
`else
        test_random_frames();
`endif
        test_timeout();
        test_reset_mid();
        checks++;
        if (viol != 0) begin
            errors++;
            $display("[TB] FAIL protocol: got %0d requests while busy, expected 0", viol);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
